// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers and counter operation type
package gray_pkg;

  // Helpers work on a fixed wide word; zero-extended narrower values convert correctly.
  localparam int GRAY_MAX_W = 64;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_LOAD,
    OP_STEP
  } gray_op_e;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic gray_word_t max_count(input int w);
    if (w >= GRAY_MAX_W) return '1;
    return (gray_word_t'(1) << w) - gray_word_t'(1);
  endfunction

endpackage

// File: rtl/gray_codec.sv
// rtl/gray_codec.sv - combinational binary<->Gray converter of one input word
module gray_codec
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_gray,
  output logic [WIDTH-1:0] o_bin
);

  assign o_gray = WIDTH'(bin2gray(gray_word_t'(i_val)));
  assign o_bin  = WIDTH'(gray2bin(gray_word_t'(i_val)));

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down binary counter with registered Gray output and boundary pulse
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(max_count(WIDTH));

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;

  logic [WIDTH-1:0] w_enc_gray;
  logic [WIDTH-1:0] w_dec_bin;
  logic [WIDTH-1:0] w_step_bin;
  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_tc;
  logic             w_at_edge;
  gray_op_e         w_op;

  gray_codec #(.WIDTH(WIDTH)) u_load_codec (
    .i_val  (load_val),
    .o_gray (w_enc_gray),
    .o_bin  (w_dec_bin)
  );

  always_comb begin
    w_op       = OP_IDLE;
    w_at_edge  = up ? (r_bin == LP_MAX) : (r_bin == '0);
    w_step_bin = up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
    w_next_bin  = r_bin;
    w_next_gray = r_gray;
    w_next_tc   = 1'b0;

    if (load)    w_op = OP_LOAD;
    else if (en) w_op = OP_STEP;

    case (w_op)
      OP_LOAD: begin
        // A Gray-coded load value is already the Gray form of the decoded binary.
        w_next_bin  = load_is_gray ? w_dec_bin : load_val;
        w_next_gray = load_is_gray ? load_val : w_enc_gray;
      end
      OP_STEP: begin
        if (w_at_edge && !WRAP) begin
          w_next_tc = 1'b1;
        end else begin
          w_next_bin  = w_step_bin;
          w_next_gray = WIDTH'(bin2gray(gray_word_t'(w_step_bin)));
          w_next_tc   = w_at_edge;
        end
      end
      default: begin
        w_next_tc = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_tc   <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_tc   <= w_next_tc;
    end
  end

  assign bin_q  = r_bin;
  assign gray_q = r_gray;
  assign tc     = r_tc;

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - self-checking bench for gray_counter (4-bit wrap, 4-bit saturate, 8-bit wrap)
module tb_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       c4_rst = 1'b1, c4_en = 1'b0, c4_up = 1'b1, c4_load = 1'b0, c4_lig = 1'b0;
  logic [3:0] c4_lv = '0;
  logic       c8_rst = 1'b1, c8_en = 1'b0, c8_up = 1'b1, c8_load = 1'b0, c8_lig = 1'b0;
  logic [7:0] c8_lv = '0;

  logic [3:0] w4_bin, w4_gray, s4_bin, s4_gray;
  logic [7:0] w8_bin, w8_gray;
  logic       w4_tc, s4_tc, w8_tc;

  gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_w4 (
    .clk(clk), .rst(c4_rst), .en(c4_en), .up(c4_up), .load(c4_load),
    .load_is_gray(c4_lig), .load_val(c4_lv), .bin_q(w4_bin), .gray_q(w4_gray), .tc(w4_tc));
  gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_s4 (
    .clk(clk), .rst(c4_rst), .en(c4_en), .up(c4_up), .load(c4_load),
    .load_is_gray(c4_lig), .load_val(c4_lv), .bin_q(s4_bin), .gray_q(s4_gray), .tc(s4_tc));
  gray_counter #(.WIDTH(8), .WRAP(1'b1)) u_w8 (
    .clk(clk), .rst(c8_rst), .en(c8_en), .up(c8_up), .load(c8_load),
    .load_is_gray(c8_lig), .load_val(c8_lv), .bin_q(w8_bin), .gray_q(w8_gray), .tc(w8_tc));

  typedef struct {
    int bin;
    bit tc;
  } mstate_t;

  mstate_t m_w4, m_s4, m_w8;
  int n_checks = 0;
  int n_errors = 0;

  // Decode by search: the binary value whose Gray image equals g.
  function automatic int gray_decode(input int g, input int width);
    for (int v = 0; v < (1 << width); v++) begin
      if ((v ^ (v >> 1)) == g) return v;
    end
    return -1;
  endfunction

  function automatic mstate_t model(input mstate_t s, input int width, input bit wrap,
                                    input bit rst, input bit en, input bit up,
                                    input bit load, input bit lig, input int lv);
    mstate_t n;
    int top;
    top = (1 << width) - 1;
    n = s;
    n.tc = 1'b0;
    if (rst) begin
      n.bin = 0;
    end else if (load) begin
      n.bin = lig ? gray_decode(lv, width) : lv;
    end else if (en) begin
      if (up && s.bin == top) begin
        n.tc = 1'b1;
        n.bin = wrap ? 0 : top;
      end else if (!up && s.bin == 0) begin
        n.tc = 1'b1;
        n.bin = wrap ? top : 0;
      end else begin
        n.bin = up ? s.bin + 1 : s.bin - 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input mstate_t m, input logic [31:0] b,
                         input logic [31:0] g, input logic t);
    chk({tag, "_bin"}, b, 32'(m.bin));
    chk({tag, "_gray"}, g, 32'(m.bin ^ (m.bin >> 1)));
    chk({tag, "_tc"}, 32'(t), 32'(m.tc));
  endtask

  // Advance one edge, update models with the inputs that edge saw, compare all DUTs.
  task automatic tick();
    @(posedge clk);
    #1;
    m_w4 = model(m_w4, 4, 1'b1, c4_rst, c4_en, c4_up, c4_load, c4_lig, int'(c4_lv));
    m_s4 = model(m_s4, 4, 1'b0, c4_rst, c4_en, c4_up, c4_load, c4_lig, int'(c4_lv));
    m_w8 = model(m_w8, 8, 1'b1, c8_rst, c8_en, c8_up, c8_load, c8_lig, int'(c8_lv));
    chk_dut("w4", m_w4, 32'(w4_bin), 32'(w4_gray), w4_tc);
    chk_dut("s4", m_s4, 32'(s4_bin), 32'(s4_gray), s4_tc);
    chk_dut("w8", m_w8, 32'(w8_bin), 32'(w8_gray), w8_tc);
  endtask

  task automatic set4(input bit en, input bit up, input bit load, input bit lig, input logic [3:0] lv);
    c4_en = en; c4_up = up; c4_load = load; c4_lig = lig; c4_lv = lv;
  endtask

  logic [3:0] gseq [0:16];
  logic [3:0] prev_gray;

  initial begin
    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    m_w4 = '{0, 1'b0}; m_s4 = '{0, 1'b0}; m_w8 = '{0, 1'b0};

    // Reset with load and en asserted: reset must win.
    c4_rst = 1'b1; c8_rst = 1'b1;
    set4(1'b1, 1'b1, 1'b1, 1'b0, 4'b1010);
    tick();
    tick();
    chk("reset_bin", 32'(w4_bin), 32'd0);
    chk("reset_gray", 32'(w4_gray), 32'd0);
    chk("reset_tc", 32'(w4_tc), 32'd0);

    // Full up sweep through the wrap edge.
    c4_rst = 1'b0;
    set4(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    prev_gray = w4_gray;
    chk("seq0", 32'(w4_gray), 32'(gseq[0]));
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("seq%0d", k), 32'(w4_gray), 32'(gseq[k]));
      chk($sformatf("seq_tc%0d", k), 32'(w4_tc), 32'(k == 16));
      chk($sformatf("onebit%0d", k), $countones(prev_gray ^ w4_gray), 32'd1);
      prev_gray = w4_gray;
    end
    tick();
    chk("seq17_gray", 32'(w4_gray), 32'b0001);

    // Down-wrap from zero, then idle clears tc.
    set4(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    set4(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    chk("dnwrap_bin", 32'(w4_bin), 32'b1111);
    chk("dnwrap_gray", 32'(w4_gray), 32'b1000);
    chk("dnwrap_tc", 32'(w4_tc), 32'd1);
    chk("sat_dn_bin", 32'(s4_bin), 32'd0);
    chk("sat_dn_tc", 32'(s4_tc), 32'd1);
    set4(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    chk("idle_tc", 32'(w4_tc), 32'd0);
    chk("idle_bin", 32'(w4_bin), 32'b1111);

    // Gray load beats a simultaneous step.
    set4(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101);
    tick();
    chk("gload_bin", 32'(w4_bin), 32'b1001);
    chk("gload_gray", 32'(w4_gray), 32'b1101);
    chk("gload_tc", 32'(w4_tc), 32'd0);

    // Loading a boundary value does not raise tc.
    set4(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111);
    tick();
    chk("bload_tc", 32'(s4_tc), 32'd0);

    // Saturating counter: 1110 -> 1111, then two blocked steps, then down.
    set4(1'b0, 1'b1, 1'b1, 1'b0, 4'b1110);
    tick();
    set4(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    chk("sat1_bin", 32'(s4_bin), 32'b1111);
    chk("sat1_tc", 32'(s4_tc), 32'd0);
    tick();
    chk("sat2_bin", 32'(s4_bin), 32'b1111);
    chk("sat2_tc", 32'(s4_tc), 32'd1);
    tick();
    chk("sat3_bin", 32'(s4_bin), 32'b1111);
    chk("sat3_tc", 32'(s4_tc), 32'd1);
    c4_up = 1'b0;
    tick();
    chk("satdn_bin", 32'(s4_bin), 32'b1110);
    chk("satdn_tc", 32'(s4_tc), 32'd0);
    set4(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // 8-bit random run against the model, with occasional mid-count reset.
    c8_rst = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      c8_rst  = ($urandom_range(0, 299) == 0);
      c8_load = ($urandom_range(0, 9) == 0);
      c8_lig  = 1'($urandom_range(0, 1));
      c8_lv   = 8'($urandom);
      c8_en   = ($urandom_range(0, 9) < 8);
      c8_up   = ($urandom_range(0, 3) != 0) ^ n[10];
      tick();
      if (c8_rst) begin
        chk("rnd_rst_bin", 32'(w8_bin), 32'd0);
        chk("rnd_rst_gray", 32'(w8_gray), 32'd0);
        chk("rnd_rst_tc", 32'(w8_tc), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
